// File: rtl/user_module.sv
// user_module: synchronized edge detector with a retriggerable pulse stretcher
module user_module #(
   parameter int EDGE_MODE   = 0,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic in,
   output logic out
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_hit;
   logic [7:0]             r_cnt;
   logic                   r_out;
   logic [SYNC_STAGES:0]   w_shift;
   logic                   w_last;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_hit;
   assign w_shift = {r_sync, in};
   assign w_last  = r_sync[SYNC_STAGES-1];
   assign w_rise  = w_last & ~r_prev;
   assign w_fall  = ~w_last & r_prev;
   assign w_hit   = EDGE_MODE == 0 ? w_rise : EDGE_MODE == 1 ? w_fall : (w_rise | w_fall);
   // Sync chain and edge history, then a registered hit that loads the stretch counter;
   // the hit register puts the first output high SYNC_STAGES+1 edges after capture.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_hit  <= 1'b0;
         r_cnt  <= 8'd0;
         r_out  <= 1'b0;
      end else begin
         r_sync <= w_shift[SYNC_STAGES-1:0];
         r_prev <= w_last;
         r_hit  <= w_hit;
         r_cnt  <= r_hit ? 8'(PULSE_LEN) : r_cnt - 8'(r_cnt != 8'd0);
         r_out  <= r_hit | (r_cnt > 8'd1);
      end
   end
   assign out = r_out;
endmodule

// File: tb/tb_user_module.sv
// tb_user_module: queue scoreboard against a behavioural model over five parameter sets
module tb_user_module;
   localparam int N = 5;
   logic         clk  = 1'b0;
   logic         rstn = 1'b0;
   logic         in   = 1'b0;
   logic [N-1:0] o;
   int           em [N] = '{0, 2, 0, 1, 5};
   int           ss [N] = '{2, 2, 2, 1, 4};
   int           pl [N] = '{1, 1, 4, 3, 2};
   int           checks = 0;
   int           errors = 0;
   int           n = 0;
   bit           started = 1'b0;
   bit           sched [N][1024];
   bit           lastv [N];
   logic [N-1:0] exp_q [$];

   user_module u0 (.clk(clk), .rstn(rstn), .in(in), .out(o[0]));
   user_module #(.EDGE_MODE(2)) u1 (.clk(clk), .rstn(rstn), .in(in), .out(o[1]));
   user_module #(.PULSE_LEN(4)) u2 (.clk(clk), .rstn(rstn), .in(in), .out(o[2]));
   user_module #(.EDGE_MODE(1), .SYNC_STAGES(1), .PULSE_LEN(3)) u3 (.clk(clk), .rstn(rstn), .in(in), .out(o[3]));
   user_module #(.EDGE_MODE(5), .SYNC_STAGES(4), .PULSE_LEN(2)) u4 (.clk(clk), .rstn(rstn), .in(in), .out(o[4]));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: out=%b expected %b", tag, got, exp);
      end
   endtask

   // v is the value in holds at the sampling edge; a glitch pulses in high between edges
   task automatic step(input bit v, input bit r, input bit glitch);
      logic [N-1:0] e;
      bit           hit;
      @(negedge clk);
      rstn = r;
      if (glitch) begin
         in = 1'b0;
         #1 in = 1'b1;
         #2 in = 1'b0;
      end else in = v;
      if (!r) started = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (!r) begin
            lastv[i] = 1'b0;
            for (int k = n; k < 1024; k++) sched[i][k] = 1'b0;
         end else begin
            hit = (v && !lastv[i] && em[i] != 1) || (!v && lastv[i] && em[i] != 0);
            if (hit)
               for (int k = 0; k < pl[i]; k++)
                  if (n + ss[i] + 1 + k < 1024) sched[i][n + ss[i] + 1 + k] = 1'b1;
            lastv[i] = v;
         end
         e[i] = sched[i][n];
      end
      if (started) exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (started) begin
         if (exp_q.size() == 0) check("queue_empty", 1'b1, 1'b0);
         else begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) check($sformatf("u%0d_cyc%0d", i, n), o[i], e[i]);
         end
      end
      n++;
   endtask

   task automatic hold(input bit v, input bit r, input int cnt);
      for (int j = 0; j < cnt; j++) step(v, r, 1'b0);
   endtask

   initial begin
      bit cur;
      hold(0, 0, 2);
      hold(0, 1, 8);
      hold(1, 1, 10);
      hold(0, 1, 10);
      hold(1, 1, 2);
      hold(0, 1, 2);
      hold(1, 1, 2);
      hold(0, 1, 8);
      hold(1, 1, 1);
      hold(0, 1, 1);
      hold(1, 1, 10);
      hold(0, 1, 10);
      hold(1, 1, 4);
      step(0, 0, 0);
      hold(0, 1, 12);
      repeat (4) step(0, 1, 1);
      hold(0, 1, 6);
      hold(1, 0, 2);
      hold(1, 1, 10);
      hold(0, 1, 10);
      cur = 1'b0;
      for (int j = 0; j < 300; j++) begin
         if ($urandom_range(0, 3) == 0) cur = ~cur;
         if (!cur && $urandom_range(0, 9) == 0) step(0, 1, 1);
         else step(cur, $urandom_range(0, 60) != 0, 0);
      end
      hold(0, 1, 12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
